// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexed driver for a DIGIT_COUNT-digit common-anode seven-segment display.
//   One digit is scanned per slot of PRESCALE cycles. The first BLANK_CYCLES cycles of
//   each slot keep everything dark to stop the previous digit ghosting into the next.
//   New values are double-buffered: a load lands in a pending copy and is promoted to the
//   displayed copy only at the start of a frame, so a frame never mixes two loads.
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high
//   load           in   capture value/pointEnable/digitMask this cycle
//   value          in   packed nibbles, nibble k drives digit k (digit 0 = rightmost)
//   pointEnable    in   bit k lights the decimal point of digit k
//   digitMask      in   bit k = 0 keeps digit k dark
//   segmentEnableN out  active-low {dp,g,f,e,d,c,b,a}
//   digitEnableN   out  active-low digit select, at most one bit low
//   frameStart     out  one-cycle pulse on cycle 0 of slot 0
//
// Timing model: cnt_q/idx_q hold the slot position that the next clock edge renders into the
// registered outputs. So the edge that samples reset low renders cycle 0 of slot 0, and a load
// sampled by that same edge is already part of the frame it starts.
module seven_segment_scanner #(
  parameter int unsigned DIGIT_COUNT        = 4,
  parameter int unsigned PRESCALE           = 50000,
  parameter int unsigned BLANK_CYCLES       = 16,
  parameter int unsigned LEADING_ZERO_BLANK = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic [4*DIGIT_COUNT-1:0] value,
  input  logic [DIGIT_COUNT-1:0]   pointEnable,
  input  logic [DIGIT_COUNT-1:0]   digitMask,
  output logic [7:0]               segmentEnableN,
  output logic [DIGIT_COUNT-1:0]   digitEnableN,
  output logic                     frameStart
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IdxW = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;
  localparam int unsigned ValW = 4 * DIGIT_COUNT;

  typedef enum logic {
    StBlank,
    StDrive
  } phase_e;

  // With no blanking configured a slot starts straight in the drive phase.
  localparam phase_e FirstPhase = (BLANK_CYCLES == 0) ? StDrive : StBlank;

  // Slot position and phase
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  phase_e          phase_q, phase_d;
  logic            slot_end;
  logic            frame;

  // Pending (last load) and active (currently displayed) copies
  logic [ValW-1:0]        pend_val_q, pend_val_d;
  logic [DIGIT_COUNT-1:0] pend_pt_q, pend_pt_d;
  logic [DIGIT_COUNT-1:0] pend_mask_q, pend_mask_d;
  logic [ValW-1:0]        act_val_q, act_val_d;
  logic [DIGIT_COUNT-1:0] act_pt_q, act_pt_d;
  logic [DIGIT_COUNT-1:0] act_mask_q, act_mask_d;

  // Registered outputs
  logic [7:0]             seg_q, seg_d;
  logic [DIGIT_COUNT-1:0] dig_q, dig_d;
  logic                   fs_q, fs_d;

  // Current-digit decode
  logic [3:0] nibble;
  logic       point;
  logic       shown;
  logic       suppress;
  logic       run_zero;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h7C;
      4'hC:    g = 7'h39;
      4'hD:    g = 7'h5E;
      4'hE:    g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Slot counter, digit index and blank/drive phase
  always_comb begin
    cnt_d    = cnt_q + CntW'(1);
    idx_d    = idx_q;
    phase_d  = phase_q;
    slot_end = (cnt_q == CntW'(PRESCALE - 1));
    frame    = (cnt_q == '0) && (idx_q == '0);
    if (slot_end) begin
      cnt_d   = '0;
      idx_d   = (idx_q == IdxW'(DIGIT_COUNT - 1)) ? '0 : idx_q + IdxW'(1);
      phase_d = FirstPhase;
    end else if ((phase_q == StBlank) && (cnt_q == CntW'(BLANK_CYCLES - 1))) begin
      phase_d = StDrive;
    end
  end

  // Double buffering: a load arriving on the frame edge bypasses pending so it is shown at once.
  always_comb begin
    pend_val_d  = pend_val_q;
    pend_pt_d   = pend_pt_q;
    pend_mask_d = pend_mask_q;
    act_val_d   = act_val_q;
    act_pt_d    = act_pt_q;
    act_mask_d  = act_mask_q;
    if (load) begin
      pend_val_d  = value;
      pend_pt_d   = pointEnable;
      pend_mask_d = digitMask;
    end
    if (frame) begin
      act_val_d  = pend_val_d;
      act_pt_d   = pend_pt_d;
      act_mask_d = pend_mask_d;
    end
  end

  // Pick the digit being rendered and decide leading-zero suppression. Walking from the most
  // significant digit down, run_zero stays set while every nibble seen so far is zero.
  always_comb begin
    nibble   = 4'h0;
    point    = 1'b0;
    shown    = 1'b0;
    suppress = 1'b0;
    run_zero = 1'b1;
    for (int k = DIGIT_COUNT - 1; k >= 0; k--) begin
      run_zero = run_zero && (act_val_d[4*k +: 4] == 4'h0);
      if (k == int'(idx_q)) begin
        nibble   = act_val_d[4*k +: 4];
        point    = act_pt_d[k];
        shown    = act_mask_d[k];
        suppress = (LEADING_ZERO_BLANK != 0) && (k != 0) && run_zero;
      end
    end
  end

  // Output next-state
  always_comb begin
    seg_d = 8'hFF;
    dig_d = '1;
    fs_d  = frame;
    if ((phase_q == StDrive) && shown) begin
      seg_d = ~{point, (suppress ? 7'h00 : glyph(nibble))};
      for (int k = 0; k < DIGIT_COUNT; k++) begin
        dig_d[k] = (k != int'(idx_q));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      phase_q <= FirstPhase;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_val_q  <= '0;
      pend_pt_q   <= '0;
      pend_mask_q <= '1;
      act_val_q   <= '0;
      act_pt_q    <= '0;
      act_mask_q  <= '1;
      seg_q       <= 8'hFF;
      dig_q       <= '1;
      fs_q        <= 1'b0;
    end else begin
      pend_val_q  <= pend_val_d;
      pend_pt_q   <= pend_pt_d;
      pend_mask_q <= pend_mask_d;
      act_val_q   <= act_val_d;
      act_pt_q    <= act_pt_d;
      act_mask_q  <= act_mask_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
      fs_q        <= fs_d;
    end
  end

  assign segmentEnableN = seg_q;
  assign digitEnableN   = dig_q;
  assign frameStart     = fs_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench: two scanners (leading-zero blanking on and off) share one stimulus.
// DIGIT_COUNT=4, PRESCALE=8, BLANK_CYCLES=2, so a frame is 32 cycles.
module tb_seven_segment_scanner;

  localparam int unsigned P     = 8;
  localparam int unsigned B     = 2;
  localparam int unsigned Frame = 4 * P;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load  = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  point_enable = 4'h0;
  logic [3:0]  digit_mask   = 4'hF;

  logic [7:0]  seg_lz, seg_nz;
  logic [3:0]  dig_lz, dig_nz;
  logic        fs_lz, fs_nz;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  seven_segment_scanner #(
    .DIGIT_COUNT(4), .PRESCALE(P), .BLANK_CYCLES(B), .LEADING_ZERO_BLANK(1)
  ) dut_lz (
    .clock(clock), .reset(reset), .load(load), .value(value),
    .pointEnable(point_enable), .digitMask(digit_mask),
    .segmentEnableN(seg_lz), .digitEnableN(dig_lz), .frameStart(fs_lz)
  );

  seven_segment_scanner #(
    .DIGIT_COUNT(4), .PRESCALE(P), .BLANK_CYCLES(B), .LEADING_ZERO_BLANK(0)
  ) dut_nz (
    .clock(clock), .reset(reset), .load(load), .value(value),
    .pointEnable(point_enable), .digitMask(digit_mask),
    .segmentEnableN(seg_nz), .digitEnableN(dig_nz), .frameStart(fs_nz)
  );

  // Expected segment bytes are packed {slot3, slot2, slot1, slot0}.
  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  pts;
    logic [3:0]  mask;
    logic [31:0] lz;
    logic [31:0] nz;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " seg_lz"}, 32'(seg_lz), 32'hFF);
    chk({tag, " seg_nz"}, 32'(seg_nz), 32'hFF);
    chk({tag, " dig_lz"}, 32'(dig_lz), 32'hF);
    chk({tag, " dig_nz"}, 32'(dig_nz), 32'hF);
    chk({tag, " fs_lz"}, 32'(fs_lz), 32'h0);
    chk({tag, " fs_nz"}, 32'(fs_nz), 32'h0);
  endtask

  // Runs one full frame starting at its frame edge, checking every cycle. If load_at >= 0 a
  // one-cycle load of (lval, lpts, lmask) is sampled by the edge of frame cycle load_at.
  task automatic check_frame(input string tag, input logic [31:0] lz, input logic [31:0] nz,
                             input logic [3:0] mask, input int load_at,
                             input logic [15:0] lval, input logic [3:0] lpts,
                             input logic [3:0] lmask);
    for (int i = 0; i < int'(Frame); i++) begin
      int         slot;
      int         cyc;
      logic [3:0] exp_dig;
      if (i == load_at) begin
        load         = 1'b1;
        value        = lval;
        point_enable = lpts;
        digit_mask   = lmask;
      end
      step();
      load = 1'b0;
      slot = i / int'(P);
      cyc  = i % int'(P);
      chk($sformatf("%s fs_lz s%0d c%0d", tag, slot, cyc), 32'(fs_lz), 32'(i == 0));
      chk($sformatf("%s fs_nz s%0d c%0d", tag, slot, cyc), 32'(fs_nz), 32'(i == 0));
      exp_dig = 4'hF;
      if (cyc >= int'(B) && mask[slot]) exp_dig[slot] = 1'b0;
      chk($sformatf("%s dig_lz s%0d c%0d", tag, slot, cyc), 32'(dig_lz), 32'(exp_dig));
      chk($sformatf("%s dig_nz s%0d c%0d", tag, slot, cyc), 32'(dig_nz), 32'(exp_dig));
      if (cyc < int'(B)) begin
        chk($sformatf("%s seg_lz s%0d c%0d", tag, slot, cyc), 32'(seg_lz), 32'hFF);
        chk($sformatf("%s seg_nz s%0d c%0d", tag, slot, cyc), 32'(seg_nz), 32'hFF);
      end else if (mask[slot]) begin
        chk($sformatf("%s seg_lz s%0d c%0d", tag, slot, cyc), 32'(seg_lz),
            32'(lz[8*slot +: 8]));
        chk($sformatf("%s seg_nz s%0d c%0d", tag, slot, cyc), 32'(seg_nz),
            32'(nz[8*slot +: 8]));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                val       pts    mask     lz            nz
    vecs[0] = '{16'h12AF, 4'h0, 4'hF,    32'hF9A4888E, 32'hF9A4888E};
    vecs[1] = '{16'h0050, 4'h0, 4'hF,    32'hFFFF92C0, 32'hC0C092C0};
    vecs[2] = '{16'h0000, 4'h0, 4'hF,    32'hFFFFFFC0, 32'hC0C0C0C0};
    vecs[3] = '{16'h8421, 4'h1, 4'b1011, 32'h80FFA479, 32'h80FFA479};
    vecs[4] = '{16'h0007, 4'h4, 4'hF,    32'hFF7FFFF8, 32'hC040C0F8};
    vecs[5] = '{16'hBCDE, 4'h0, 4'hF,    32'h83C6A186, 32'h83C6A186};
    vecs[6] = '{16'h0305, 4'h0, 4'hF,    32'hFFB0C092, 32'hC0B0C092};
    vecs[7] = '{16'h9640, 4'h0, 4'hF,    32'h908299C0, 32'h908299C0};

    // Reset held: everything dark, no frame pulse.
    reset = 1'b1;
    repeat (5) step();
    chk_dark("reset");

    // Release: first edge renders cycle 0 of slot 0 with the cleared value 0000.
    reset = 1'b0;
    check_frame("post_reset", 32'hFFFFFFC0, 32'hC0C0C0C0, 4'hF, -1, 16'h0, 4'h0, 4'hF);

    // Each vector is loaded on the frame edge and must appear in that same frame.
    for (int v = 0; v < 8; v++) begin
      check_frame($sformatf("vec%0d", v), vecs[v].lz, vecs[v].nz, vecs[v].mask, 0,
                  vecs[v].val, vecs[v].pts, vecs[v].mask);
    end

    // Load mid-frame (slot 1, cycle 3): old value held to frame end, new value next frame.
    check_frame("midload_old", 32'h908299C0, 32'h908299C0, 4'hF, int'(P) + 3,
                16'h1111, 4'h0, 4'hF);
    check_frame("midload_new", 32'hF9F9F9F9, 32'hF9F9F9F9, 4'hF, -1, 16'h0, 4'h0, 4'hF);

    // Run to slot 2 cycle 4, then reset: next cycle dark, restart shows 0000.
    for (int i = 0; i < 2 * int'(P) + 5; i++) step();
    chk("pre_reset dig_lz", 32'(dig_lz), 32'hB);
    chk("pre_reset seg_lz", 32'(seg_lz), 32'hF9);
    reset = 1'b1;
    step();
    chk_dark("midslot_reset");
    step();
    reset = 1'b0;
    check_frame("after_reset", 32'hFFFFFFC0, 32'hC0C0C0C0, 4'hF, -1, 16'h0, 4'h0, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
